// File: rtl/spi_byte_engine.sv
// Byte-wide SPI master, mode 0, one frame per accepted start with a minimum cs-high gap.
// Optional macro SPI_LSB_FIRST_EN: LSB-first transmit and receive, same frame timing.
module spi_byte_engine #(
    parameter int CLK_DIV     = 4,
    parameter int CS_IDLE_MIN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       done,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_IDLE_MIN - 1);

    state_t     r_state;
    logic [7:0] r_div;
    logic [2:0] r_bit;
    logic       r_end;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_data_out;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_cs;
    logic       r_done;
    logic       r_busy;

    logic       w_div_hit;
    logic       w_gap_hit;
    logic       w_accept;

`ifdef SPI_LSB_FIRST_EN
    function automatic logic first_bit(input logic [7:0] b);
        return b[0];
    endfunction

    function automatic logic [7:0] tx_shift(input logic [7:0] b);
        return {1'b0, b[7:1]};
    endfunction

    function automatic logic [7:0] rx_shift(input logic [7:0] r, input logic b);
        return {b, r[7:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [7:0] b);
        return b[7];
    endfunction

    function automatic logic [7:0] tx_shift(input logic [7:0] b);
        return {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] rx_shift(input logic [7:0] r, input logic b);
        return {r[6:0], b};
    endfunction
`endif

    assign w_div_hit = (r_div == DIV_LAST);
    assign w_gap_hit = (r_div == GAP_LAST);
    // The last GAP cycle may take a new request directly so back-to-back frames keep the minimum gap.
    assign w_accept  = start && ((r_state == IDLE) || ((r_state == GAP) && w_gap_hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_end      <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs       <= 1'b1;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_tx    <= data_in;
                r_mosi  <= first_bit(data_in);
                r_cs    <= 1'b0;
                r_busy  <= 1'b1;
                r_div   <= '0;
                r_bit   <= '0;
                r_end   <= 1'b0;
                r_state <= SETUP;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_div <= '0;
                    end
                    SETUP: begin
                        if (w_div_hit) begin
                            r_div   <= '0;
                            r_sclk  <= 1'b1;
                            r_rx    <= rx_shift(r_rx, miso);
                            r_state <= XFER;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    XFER: begin
                        if (w_div_hit) begin
                            r_div <= '0;
                            // r_end marks the low half of the eighth bit cell, which closes the transfer.
                            if (r_end) begin
                                r_state <= HOLD;
                            end else if (r_sclk) begin
                                r_sclk <= 1'b0;
                                r_tx   <= tx_shift(r_tx);
                                if (r_bit == 3'd7) begin
                                    r_end  <= 1'b1;
                                    r_mosi <= 1'b0;
                                end else begin
                                    r_bit  <= r_bit + 3'd1;
                                    r_mosi <= first_bit(tx_shift(r_tx));
                                end
                            end else begin
                                r_sclk <= 1'b1;
                                r_rx   <= rx_shift(r_rx, miso);
                            end
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    HOLD: begin
                        if (w_div_hit) begin
                            r_div      <= '0;
                            r_cs       <= 1'b1;
                            r_done     <= 1'b1;
                            r_data_out <= r_rx;
                            r_state    <= GAP;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    GAP: begin
                        if (w_gap_hit) begin
                            r_div   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out = r_data_out;
    assign done     = r_done;
    assign busy     = r_busy;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign cs       = r_cs;

endmodule
